// File: rtl/line_buffer_ring.sv
// N-bank line buffer ring: writer fills and commits whole lines, reader scans them out in FIFO order.
// Optional LBR_REPEAT_LAST_EN: releasing the only queued line re-arms it and pulses rd_repeat.
module line_buffer_ring #(
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 800,
    parameter int NUM_BUFS = 3,
    parameter int CNT_W    = $clog2(NUM_BUFS + 1)
) (
    input  logic              clk_pixel,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_release,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  lines_ready,
    output logic              wr_overflow,
    output logic              rd_underflow
`ifdef LBR_REPEAT_LAST_EN
    ,
    output logic              rd_repeat
`endif
);

    localparam int PTR_W     = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam int MEM_WORDS = NUM_BUFS * DEPTH;
    localparam int PHYS_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(NUM_BUFS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_BUFS);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  occ;
    logic [DATA_W-1:0] rd_word;
    logic              rd_sel;

    logic              wr_in_range;
    logic              rd_in_range;
    logic [ADDR_W-1:0] wr_addr_eff;
    logic [ADDR_W-1:0] rd_addr_eff;
    logic [PHYS_W-1:0] wr_phys;
    logic [PHYS_W-1:0] rd_phys;
    logic              commit_ok;
    logic              release_req_ok;
    logic              release_ok;
    logic              write_ok;
    logic              hold_last;

    assign wr_ready    = (occ < FULL_CNT);
    assign rd_valid    = (occ != '0);
    assign lines_ready = occ;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    // Clamp out-of-range addresses so the physical index never leaves the array.
    assign wr_addr_eff = wr_in_range ? wr_addr : '0;
    assign rd_addr_eff = rd_in_range ? rd_addr : '0;
    assign wr_phys     = PHYS_W'(wr_ptr) * PHYS_W'(DEPTH) + PHYS_W'(wr_addr_eff);
    assign rd_phys     = PHYS_W'(rd_ptr) * PHYS_W'(DEPTH) + PHYS_W'(rd_addr_eff);

    assign write_ok       = wr_en && wr_ready && wr_in_range;
    assign commit_ok      = wr_commit && wr_ready;
    assign release_req_ok = rd_release && rd_valid;

`ifdef LBR_REPEAT_LAST_EN
    // Keep the last line for re-scan unless a fresh line arrives in the same cycle.
    assign hold_last  = release_req_ok && (occ == CNT_W'(1)) && !commit_ok;
`else
    assign hold_last  = 1'b0;
`endif
    assign release_ok = release_req_ok && !hold_last;

    always_ff @(posedge clk_pixel) begin
        if (write_ok) begin
            mem[wr_phys] <= wr_data;
        end
    end

    always_ff @(posedge clk_pixel) begin
        rd_word <= mem[rd_phys];
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (commit_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (release_ok) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({commit_ok, release_ok})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // rd_sel gates the raw RAM word so rd_data reads 0 for invalid or out-of-range reads.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel       <= 1'b0;
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            rd_sel       <= rd_valid && rd_in_range;
            wr_overflow  <= (wr_en || wr_commit) && !wr_ready;
            rd_underflow <= rd_release && !rd_valid;
        end
    end

`ifdef LBR_REPEAT_LAST_EN
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            rd_repeat <= 1'b0;
        end else begin
            rd_repeat <= hold_last;
        end
    end
`endif

    assign rd_data = rd_sel ? rd_word : '0;

endmodule

// File: tb/tb_line_buffer_ring.sv
// Directed self-checking bench for line_buffer_ring (NUM_BUFS=3, DEPTH=800).
module tb_line_buffer_ring;

    localparam int DATA_W   = 24;
    localparam int ADDR_W   = 10;
    localparam int DEPTH    = 800;
    localparam int NUM_BUFS = 3;
    localparam int CNT_W    = 2;

    logic              clk_pixel = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_commit;
    logic              wr_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_release;
    logic              rd_valid;
    logic [CNT_W-1:0]  lines_ready;
    logic              wr_overflow;
    logic              rd_underflow;
`ifdef LBR_REPEAT_LAST_EN
    logic              rd_repeat;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_pixel = ~clk_pixel;

    line_buffer_ring #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_BUFS(NUM_BUFS), .CNT_W(CNT_W)
    ) dut (
        .clk_pixel(clk_pixel), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
        .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data), .rd_release(rd_release),
        .rd_valid(rd_valid), .lines_ready(lines_ready), .wr_overflow(wr_overflow),
        .rd_underflow(rd_underflow)
`ifdef LBR_REPEAT_LAST_EN
        , .rd_repeat(rd_repeat)
`endif
    );

    task automatic cycle();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic fill_line(input logic [DATA_W-1:0] base);
        for (int a = 0; a < DEPTH; a++) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(a);
            wr_data = base + DATA_W'(a);
            cycle();
        end
        wr_en = 1'b0;
    endtask

    task automatic commit_line();
        wr_commit = 1'b1;
        cycle();
        wr_commit = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_commit = 1'b0;
        rd_addr = '0; rd_release = 1'b0;
        #12;
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (lines_ready !== 2'd0) begin bad++; $display("FAIL reset_lines_ready got=%0d exp=0", lines_ready); end
        total++; if (rd_data !== 24'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=000000", rd_data); end
        total++; if (wr_overflow !== 1'b0 || rd_underflow !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", wr_overflow, rd_underflow); end
        @(negedge clk_pixel);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_underflow();
        rd_release = 1'b1;
        cycle();
        rd_release = 1'b0;
        total++; if (rd_underflow !== 1'b1) begin bad++; $display("FAIL underflow_pulse got=%b exp=1", rd_underflow); end
        total++; if (lines_ready !== 2'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL underflow_state got=%0d/%b exp=0/0", lines_ready, rd_valid); end
        cycle();
        total++; if (rd_underflow !== 1'b0) begin bad++; $display("FAIL underflow_one_cycle got=%b exp=0", rd_underflow); end
    endtask

    task automatic test_basic();
        fill_line(24'h100000);
        total++; if (lines_ready !== 2'd0) begin bad++; $display("FAIL basic_precommit got=%0d exp=0", lines_ready); end
        commit_line();
        total++; if (lines_ready !== 2'd1 || rd_valid !== 1'b1) begin bad++; $display("FAIL basic_commit got=%0d/%b exp=1/1", lines_ready, rd_valid); end
        rd_addr = 10'd5; cycle();
        total++; if (rd_data !== 24'h100005) begin bad++; $display("FAIL basic_read5 got=%h exp=100005", rd_data); end
        rd_addr = 10'd799; cycle();
        total++; if (rd_data !== 24'h10031F) begin bad++; $display("FAIL basic_read799 got=%h exp=10031f", rd_data); end
        rd_addr = 10'd900; cycle();
        total++; if (rd_data !== 24'h0) begin bad++; $display("FAIL basic_read_oob got=%h exp=000000", rd_data); end
    endtask

    task automatic test_full();
        fill_line(24'h200000); commit_line();
        fill_line(24'h300000); commit_line();
        total++; if (lines_ready !== 2'd3 || wr_ready !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=3/0", lines_ready, wr_ready); end
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = 24'hFFFFFF; wr_commit = 1'b1;
        cycle();
        wr_en = 1'b0; wr_commit = 1'b0;
        total++; if (wr_overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%b exp=1", wr_overflow); end
        total++; if (lines_ready !== 2'd3) begin bad++; $display("FAIL full_occ_held got=%0d exp=3", lines_ready); end
        cycle();
        total++; if (wr_overflow !== 1'b0) begin bad++; $display("FAIL full_overflow_one_cycle got=%b exp=0", wr_overflow); end
        rd_addr = 10'd5; cycle();
        total++; if (rd_data !== 24'h100005) begin bad++; $display("FAIL full_bank_intact got=%h exp=100005", rd_data); end
    endtask

    task automatic test_full_commit_release();
        wr_commit = 1'b1; rd_release = 1'b1;
        cycle();
        wr_commit = 1'b0; rd_release = 1'b0;
        total++; if (lines_ready !== 2'd2) begin bad++; $display("FAIL fcr_occ got=%0d exp=2", lines_ready); end
        total++; if (wr_overflow !== 1'b1) begin bad++; $display("FAIL fcr_overflow got=%b exp=1", wr_overflow); end
        rd_addr = 10'd5; cycle();
        total++; if (rd_data !== 24'h200005) begin bad++; $display("FAIL fcr_next_line got=%h exp=200005", rd_data); end
    endtask

    task automatic test_oob_write();
        wr_en = 1'b1; wr_addr = 10'd900; wr_data = 24'hABCDEF;
        cycle();
        wr_en = 1'b0;
        rd_addr = 10'd100; cycle();
        total++; if (rd_data !== 24'h200064) begin bad++; $display("FAIL oob_no_alias got=%h exp=200064", rd_data); end
        rd_release = 1'b1; cycle(); rd_release = 1'b0;
        total++; if (lines_ready !== 2'd1) begin bad++; $display("FAIL oob_release_occ got=%0d exp=1", lines_ready); end
        rd_addr = 10'd5; cycle();
        total++; if (rd_data !== 24'h300005) begin bad++; $display("FAIL oob_third_line got=%h exp=300005", rd_data); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_addr = 10'd5; wr_data = 24'h500000 + DATA_W'(i);
            cycle();
            wr_en = 1'b0; wr_commit = 1'b1; rd_release = 1'b1;
            cycle();
            wr_commit = 1'b0; rd_release = 1'b0;
            total++; if (lines_ready !== 2'd1) begin bad++; $display("FAIL b2b_occ[%0d] got=%0d exp=1", i, lines_ready); end
            rd_addr = 10'd5; cycle();
            total++; if (rd_data !== 24'h500000 + DATA_W'(i)) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rd_data, 24'h500000 + DATA_W'(i)); end
        end
    endtask

    task automatic test_release_last();
        rd_release = 1'b1;
        cycle();
        rd_release = 1'b0;
`ifdef LBR_REPEAT_LAST_EN
        total++; if (rd_repeat !== 1'b1) begin bad++; $display("FAIL repeat_pulse got=%b exp=1", rd_repeat); end
        total++; if (rd_valid !== 1'b1 || lines_ready !== 2'd1) begin bad++; $display("FAIL repeat_state got=%b/%0d exp=1/1", rd_valid, lines_ready); end
        cycle();
        total++; if (rd_repeat !== 1'b0) begin bad++; $display("FAIL repeat_one_cycle got=%b exp=0", rd_repeat); end
        rd_addr = 10'd5; cycle();
        total++; if (rd_data !== 24'h500009) begin bad++; $display("FAIL repeat_reread got=%h exp=500009", rd_data); end
`else
        total++; if (rd_valid !== 1'b0 || lines_ready !== 2'd0) begin bad++; $display("FAIL last_release_state got=%b/%0d exp=0/0", rd_valid, lines_ready); end
        total++; if (rd_underflow !== 1'b0) begin bad++; $display("FAIL last_release_no_underflow got=%b exp=0", rd_underflow); end
`endif
    endtask

    task automatic test_async_reset();
        logic [DATA_W-1:0] exp_pre;
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = 24'h777777;
        cycle();
        wr_en = 1'b0;
        commit_line();
`ifdef LBR_REPEAT_LAST_EN
        exp_pre = 24'h500009;
`else
        exp_pre = 24'h777777;
`endif
        rd_addr = 10'd5; cycle();
        total++; if (rd_data !== exp_pre) begin bad++; $display("FAIL areset_pre_data got=%h exp=%h", rd_data, exp_pre); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (lines_ready !== 2'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("FAIL areset_state got=%0d/%b/%b exp=0/0/1", lines_ready, rd_valid, wr_ready); end
        total++; if (rd_data !== 24'h0) begin bad++; $display("FAIL areset_rd_data got=%h exp=000000", rd_data); end
        total++; if (wr_overflow !== 1'b0 || rd_underflow !== 1'b0) begin bad++; $display("FAIL areset_pulses got=%b%b exp=00", wr_overflow, rd_underflow); end
        @(negedge clk_pixel);
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_basic();
        test_full();
        test_full_commit_release();
        test_oob_write();
        test_back_to_back();
        test_release_last();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
